// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcodes, FSM state codes, datapath mux encodings
// and the control-word payload driven by the multi-cycle sequencer.
package cpu_pkg;

    localparam int unsigned STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd1;
    localparam logic [5:0] OP_LW    = 6'd2;
    localparam logic [5:0] OP_SW    = 6'd3;
    localparam logic [5:0] OP_ADDI  = 6'd4;
    localparam logic [5:0] OP_ANDI  = 6'd5;
    localparam logic [5:0] OP_XORI  = 6'd6;
    localparam logic [5:0] OP_SLTI  = 6'd7;
    localparam logic [5:0] OP_J     = 6'd8;
    localparam logic [5:0] OP_JAL   = 6'd9;
    localparam logic [5:0] OP_JR    = 6'd10;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_EXEC_R   = 4'd2;
    localparam state_t S_EXEC_I   = 4'd3;
    localparam state_t S_ALU_WB   = 4'd4;
    localparam state_t S_MEM_ADDR = 4'd5;
    localparam state_t S_MEM_RD   = 4'd6;
    localparam state_t S_MEM_WB   = 4'd7;
    localparam state_t S_MEM_WR   = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JUMP     = 4'd10;
    localparam state_t S_JAL_WB   = 4'd11;
    localparam state_t S_JR_EX    = 4'd12;
    localparam state_t S_TRAP     = 4'd13;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_IMM   = 2'b10;
    localparam logic [1:0] ALU_RTYPE = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       link;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; wraps naturally at 2^CNT_W.
module retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/write-back
// with a memory ready handshake, sticky illegal-opcode trap and retire counter.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                link,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_o
);

    state_t state;
    state_t next_state;
    ctl_t   ctl;
    ctl_t   ctl_out;
    logic   inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; FETCH/BRANCH enables are Mealy, rest Moore.
    always_comb begin
        next_state = state;
        ctl        = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.pc_source = PC_ALU;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    next_state   = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OPCODE_W'(OP_RTYPE): next_state = S_EXEC_R;
                    OPCODE_W'(OP_ADDI),
                    OPCODE_W'(OP_ANDI),
                    OPCODE_W'(OP_XORI),
                    OPCODE_W'(OP_SLTI):  next_state = S_EXEC_I;
                    OPCODE_W'(OP_LW),
                    OPCODE_W'(OP_SW):    next_state = S_MEM_ADDR;
                    OPCODE_W'(OP_BEQ):   next_state = S_BRANCH;
                    OPCODE_W'(OP_J):     next_state = S_JUMP;
                    OPCODE_W'(OP_JAL):   next_state = S_JAL_WB;
                    OPCODE_W'(OP_JR):    next_state = S_JR_EX;
                    default:             next_state = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RT;
                ctl.alu_op    = ALU_RTYPE;
                next_state    = S_ALU_WB;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = (opcode == OPCODE_W'(OP_ADDI)) ? ALU_ADD : ALU_IMM;
                next_state    = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = (opcode == OPCODE_W'(OP_RTYPE));
                next_state    = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
                next_state    = (opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctl.mem_req = 1'b1;
                ctl.i_or_d  = 1'b1;
                if (mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                next_state     = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.mem_req = 1'b1;
                ctl.mem_we  = 1'b1;
                ctl.i_or_d  = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RT;
                ctl.alu_op    = ALU_SUB;
                ctl.pc_source = PC_ALUOUT;
                ctl.pc_write  = alu_zero;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PC_JUMP;
                next_state    = S_FETCH;
            end
            S_JAL_WB: begin
                ctl.reg_write = 1'b1;
                ctl.link      = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PC_JUMP;
                next_state    = S_FETCH;
            end
            S_JR_EX: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PC_RS;
                next_state    = S_FETCH;
            end
            S_TRAP: begin
                ctl.illegal = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Reset must kill every enable in the same cycle, including FETCH's mem_req.
    assign ctl_out    = rst ? '0 : ctl;
    assign mem_req    = ctl_out.mem_req;
    assign mem_we     = ctl_out.mem_we;
    assign i_or_d     = ctl_out.i_or_d;
    assign ir_write   = ctl_out.ir_write;
    assign pc_write   = ctl_out.pc_write;
    assign reg_write  = ctl_out.reg_write;
    assign reg_dst    = ctl_out.reg_dst;
    assign mem_to_reg = ctl_out.mem_to_reg;
    assign link       = ctl_out.link;
    assign alu_src_a  = ctl_out.alu_src_a;
    assign alu_src_b  = ctl_out.alu_src_b;
    assign alu_op     = ctl_out.alu_op;
    assign pc_source  = ctl_out.pc_source;
    assign illegal    = ctl_out.illegal;
    assign state_o    = rst ? 4'(S_FETCH) : 4'(state);

    assign inc = (state != S_FETCH) && (next_state == S_FETCH);

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .count (retired)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction stream checked cycle-by-cycle
// against a per-instruction control-sequence model, plus directed trap/reset cases.
module tb_multicycle_control;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned CNT_W    = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [OPCODE_W-1:0] opcode;
    logic                alu_zero;
    logic                mem_ready;
    logic                mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write;
    logic                reg_dst, mem_to_reg, link, alu_src_a, illegal;
    logic [1:0]          alu_src_b, alu_op, pc_source;
    logic [CNT_W-1:0]    retired;
    logic [3:0]          state_o;

    int                  n_cmp = 0;
    int                  n_err = 0;
    logic [CNT_W-1:0]    exp_ret;
    logic [16:0]         obs;

    multicycle_control #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .link(link), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal(illegal), .retired(retired), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dst,
                  mem_to_reg, link, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

    function automatic logic [16:0] cw(input logic req, we, iod, irw, pcw, rw, rd, m2r, lnk,
                                       srca, input logic [1:0] srcb, aop, pcs, input logic ill);
        return {req, we, iod, irw, pcw, rw, rd, m2r, lnk, srca, srcb, aop, pcs, ill};
    endfunction

    task automatic check_vec(input string tag, input logic [16:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic check_ret(input string tag);
        n_cmp++;
        assert (retired === exp_ret) else begin
            n_err++;
            $error("FAIL %s: retired observed=%0d expected=%0d", tag, retired, exp_ret);
        end
    endtask

    // One clock cycle: drive mem_ready on the falling edge, check, then wait for the rise.
    task automatic step(input logic mr, input logic [16:0] exp, input string tag);
        @(negedge clk);
        mem_ready = mr;
        #1;
        check_vec(tag, exp);
        @(posedge clk);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fetch_decode(input int fw);
        for (int i = 0; i < fw; i++)
            step(1'b0, cw(1,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch_wait");
        step(1'b1, cw(1,0,0,1,1,0,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch");
        step(rnd_bit(), cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), "decode");
    endtask

    // Expected per-cycle control words for one whole legal instruction.
    task automatic run_instr(input int op, input logic az, input int fw, input int mw);
        opcode   = OPCODE_W'(op);
        alu_zero = az;
        fetch_decode(fw);
        case (op)
            0: begin
                step(rnd_bit(), cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b11,2'b00,0), "exec_r");
                step(rnd_bit(), cw(0,0,0,0,0,1,1,0,0,0,2'b00,2'b00,2'b00,0), "alu_wb_r");
            end
            4, 5, 6, 7: begin
                step(rnd_bit(), cw(0,0,0,0,0,0,0,0,0,1,2'b10,(op == 4) ? 2'b00 : 2'b10,2'b00,0), "exec_i");
                step(rnd_bit(), cw(0,0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0), "alu_wb_i");
            end
            2: begin
                step(rnd_bit(), cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "mem_addr_lw");
                for (int i = 0; i < mw; i++)
                    step(1'b0, cw(1,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "mem_rd_wait");
                step(1'b1, cw(1,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "mem_rd");
                step(rnd_bit(), cw(0,0,0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0), "mem_wb");
            end
            3: begin
                step(rnd_bit(), cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "mem_addr_sw");
                for (int i = 0; i < mw; i++)
                    step(1'b0, cw(1,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "mem_wr_wait");
                step(1'b1, cw(1,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "mem_wr");
            end
            1:  step(rnd_bit(), cw(0,0,0,0,az,0,0,0,0,1,2'b00,2'b01,2'b01,0), "branch");
            8:  step(rnd_bit(), cw(0,0,0,0,1,0,0,0,0,0,2'b00,2'b00,2'b10,0), "jump");
            9:  step(rnd_bit(), cw(0,0,0,0,1,1,0,0,1,0,2'b00,2'b00,2'b10,0), "jal");
            default: step(rnd_bit(), cw(0,0,0,0,1,0,0,0,0,0,2'b00,2'b00,2'b11,0), "jr");
        endcase
        exp_ret = exp_ret + CNT_W'(1);
        #1;
        check_ret("retired_after_instr");
    endtask

    // Assert reset mid-cycle, check everything is dead at once, then release.
    task automatic do_reset(input string tag);
        @(negedge clk);
        mem_ready = 1'b0;
        rst       = 1'b1;
        exp_ret   = '0;
        #1;
        check_vec({tag, "_outputs"}, 17'h0);
        check_ret({tag, "_retired"});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_vec({tag, "_release"}, cw(1,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
        @(posedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        opcode    = '0;
        exp_ret   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset_outputs", 17'h0);
        check_ret("reset_retired");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_vec("first_cycle_fetch", cw(1,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
        @(posedge clk);

        // Directed: R-type, LW with 2 wait states, BEQ taken/not-taken, JAL.
        run_instr(0, 1'b0, 0, 0);
        run_instr(2, 1'b0, 0, 2);
        run_instr(1, 1'b1, 0, 0);
        run_instr(1, 1'b0, 0, 0);
        run_instr(9, 1'b0, 0, 0);

        // Randomized legal instruction stream with random wait states.
        for (int n = 0; n < 60; n++)
            run_instr(int'($urandom_range(0, 10)), rnd_bit(),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

        // Illegal opcode: sticky trap, no enables, retired frozen, cleared by reset.
        opcode = 6'b111111;
        fetch_decode(0);
        for (int i = 0; i < 20; i++)
            step(rnd_bit(), cw(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), "trap_hold");
        #1;
        check_ret("trap_retired_frozen");
        do_reset("trap_reset");
        run_instr(8, 1'b0, 1, 0);

        // Reset while SW is waiting in MEM_WR.
        opcode = OPCODE_W'(3);
        fetch_decode(0);
        step(rnd_bit(), cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "sw_addr");
        step(1'b0, cw(1,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "sw_wait");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_vec("sw_wait_pre_reset", cw(1,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        do_reset("memwr_reset");
        run_instr(0, 1'b0, 0, 0);
        run_instr(3, 1'b0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
